// File: rtl/md_unit.sv
// Iterative radix-2 multiply/divide unit with private HI/LO registers.
// One operation takes WIDTH+1 busy cycles: WIDTH shift steps, then one sign-fix/write cycle.
module md_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             is_div, neg_q, neg_r, div0;
    logic [WIDTH-1:0] opnd;   // multiplicand or divisor
    logic [WIDTH-1:0] a_raw;  // unmodified dividend for the divide-by-zero result
    logic [WIDTH-1:0] rem;    // product high half or partial remainder
    logic [WIDTH-1:0] low;    // multiplier bits shifting out / quotient bits shifting in

    logic             accept, fin;
    logic             sgn, a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod;

    assign accept = (state == IDLE) && start && !cancel;
    assign busy   = (state != IDLE);

    assign sgn   = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg = sgn && a[WIDTH-1];
    assign b_neg = sgn && b[WIDTH-1];
    assign abs_a = a_neg ? -a : a;
    assign abs_b = b_neg ? -b : b;

    assign mul_sum   = {1'b0, rem} + {1'b0, (low[0] ? opnd : {WIDTH{1'b0}})};
    assign div_shift = {rem, low[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign prod      = {rem, low};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        fin      = 1'b0;
        case (state)
            IDLE: if (accept && !op[2]) state_nx = CALC;
            CALC: begin
                if (cancel)                 state_nx = IDLE;
                else if (cnt == CNT_W'(1))  state_nx = FIX;
            end
            FIX: begin
                state_nx = IDLE;
                fin      = !cancel;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            opnd   <= '0;
            a_raw  <= '0;
            rem    <= '0;
            low    <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= fin;
            if (accept) begin
                if (op == OP_MTHI)      hi <= a;
                else if (op == OP_MTLO) lo <= a;
                else if (!op[2]) begin
                    cnt    <= CNT_W'(WIDTH);
                    is_div <= op[1];
                    neg_q  <= a_neg ^ b_neg;
                    neg_r  <= a_neg;
                    div0   <= op[1] && (b == '0);
                    a_raw  <= a;
                    rem    <= '0;
                    opnd   <= op[1] ? abs_b : abs_a;
                    low    <= op[1] ? abs_a : abs_b;
                end
            end
            if (state == CALC) begin
                cnt <= cnt - CNT_W'(1);
                if (is_div) begin
                    // Restoring step: keep the difference only when it did not go negative.
                    rem <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                    low <= {low[WIDTH-2:0], ~div_diff[WIDTH]};
                end else begin
                    rem <= mul_sum[WIDTH:1];
                    low <= {mul_sum[0], low[WIDTH-1:1]};
                end
            end
            if (fin) begin
                if (is_div && div0) begin
                    hi <= a_raw;
                    lo <= '1;
                end else if (is_div) begin
                    hi <= neg_r ? -rem : rem;
                    lo <= neg_q ? -low : low;
                end else begin
                    {hi, lo} <= neg_q ? -prod : prod;
                end
            end
        end
    end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised iterative multiply/divide unit with its own HI/LO registers.
- Serves the MULT, MULTU, DIV, DIVU, MTHI and MTLO instructions, and supplies HI/LO for MFHI/MFLO.
- Generalises the earlier fixed-width, purely combinational multiplier and divider into one WIDTH-generic radix-2 engine, adding:
  - a start/busy/done handshake for pipeline stall,
  - cancel on exception,
  - fully defined divide-by-zero and signed-overflow results.

Parameters:
- WIDTH, 32: operand, HI and LO width in bits; must be even and ≥ 4.
- CNT_W, $clog2(WIDTH)+1: iteration counter width.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- start, input, 1: request; sampled only while busy=0.
- op, input, 3: operation select. 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are no-ops.
- a, input, WIDTH: rs operand (multiplicand, dividend, or move data).
- b, input, WIDTH: rt operand (multiplier, divisor).
- cancel, input, 1: abort the in-flight operation (exception or ERET flush).
- busy, output, 1: engine occupied; the core stalls any HI/LO access while busy=1.
- done, output, 1: one-cycle pulse; HI/LO hold the new result in that cycle.
- hi, output, WIDTH: HI register.
- lo, output, WIDTH: LO register.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset mid-operation discards the work immediately.
- States: IDLE → CALC → FIX → IDLE.
- IDLE, edge E0 with start=1:
  - MULT/MULTU/DIV/DIVU:
    - latch |a| and |b| for signed ops, raw values for unsigned ops;
    - latch the result sign flags;
    - counter=WIDTH; go to CALC; busy=1 from E0.
  - MTHI: hi←a at E0. MTLO: lo←a at E0. Stay IDLE, busy stays 0, no done.
  - No-op codes: nothing happens.
- CALC, one iteration per edge, WIDTH edges (E1..E_WIDTH):
  - Multiply: shift-add on a 2*WIDTH-bit accumulator.
  - Divide: restoring shift-subtract; remainder is WIDTH+1 bits.
  - Counter decrements each edge; at 0, go to FIX.
- FIX, edge E_WIDTH+1:
  - Apply sign correction.
  - Write hi/lo; busy←0; done←1 for exactly one cycle; go to IDLE.
  - Total occupancy: busy=1 for WIDTH+1 cycles.
- Start while busy=1: ignored, including MTHI/MTLO. The core holds start and the instruction until busy=0.
- Back-to-back: start may be asserted in the done cycle. It is accepted at that edge (busy=0 then).
- Results:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product, signed or unsigned.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
- Divide by zero (b=0, DIV or DIVU): hi=a (original, unmodified), lo=all ones. Normal latency, no exception raised.
- Signed overflow (DIV, a=100..0, b=all ones): lo=100..0, hi=0.
- cancel=1 while busy:
  - next edge returns to IDLE, busy=0, no done;
  - hi/lo keep their pre-start values.
  - cancel and start together in IDLE: cancel wins and the start is dropped.
  - cancel in IDLE otherwise has no effect.
- cancel in the FIX cycle: the result is dropped, hi/lo are not written, and done stays 0.
- Operands a/b may change after E0 without affecting the in-flight result.

Test Plan (WIDTH=32; done expected 33 edges after acceptance):
- MULT a=0xFFFFFFFD (-3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 33 cycles; done pulses once.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then immediately start MULTU 2×3 in the done cycle → hi=0, lo=6.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 → hi=7, lo=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. DIV a=7, b=-2 → lo=0xFFFFFFFD, hi=1.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles → each register updates after one edge; busy never rises. Then start DIVU; assert start with MTHI at edge 5 (ignored); assert cancel at edge 10 → busy=0 next cycle, no done, hi=0x12345678, lo=0x9ABCDEF0.
- Start MULT, drive rst=0 asynchronously mid-CALC (between edges) → busy=0, hi=lo=0 before the next edge. After rst=1, a new MULTU 5×5 gives lo=25.
